// File: rtl/line_burst_pkg.sv
// Shared types and default geometry for the cache line <-> memory burst adaptor.
package line_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int S_LINE  = 256;
  localparam int S_BURST = 64;
  localparam int BEATS   = S_LINE / S_BURST;
  localparam int CNT_W   = $clog2(BEATS);

endpackage

// File: rtl/line_burst_adaptor_if.sv
// Cache-side line request signals plus memory-side burst signals of one adaptor.
interface line_burst_adaptor_if #(
  parameter int s_addr  = 32,
  parameter int s_line  = 256,
  parameter int s_burst = 64
);

  logic [s_addr-1:0]  address_i;
  logic               read_i;
  logic               write_i;
  logic [s_line-1:0]  line_i;
  logic [s_line-1:0]  line_o;
  logic               resp_o;

  logic [s_addr-1:0]  address_o;
  logic               read_o;
  logic               write_o;
  logic [s_burst-1:0] burst_o;
  logic [s_burst-1:0] burst_i;
  logic               resp_i;

  // master: the cache controller plus memory model around the adaptor
  modport master (
    output address_i, read_i, write_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  // slave: the adaptor itself
  modport slave (
    input  address_i, read_i, write_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

endinterface

// File: rtl/line_burst_adaptor.sv
// Assembles four memory beats into a cache line on fill, splits a line into beats on writeback.
// Request to read_o/write_o: 1 cycle; last beat to resp_o: 1 cycle; resp_i=0 stalls a beat.
module line_burst_adaptor
  import line_burst_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_addr   = 32
) (
  input logic                 clk,
  input logic                 rst,
  line_burst_adaptor_if.slave bus
);

  localparam int beats = s_line / s_burst;
  localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
  localparam logic [s_addr-1:0] line_mask = ~s_addr'((64'd1 << s_offset) - 64'd1);

  state_t            state;
  state_t            state_nxt;
  logic [cnt_w-1:0]  cnt;
  logic [s_line-1:0] wb_line;
  logic [s_line-1:0] fill_line;
  logic [s_addr-1:0] addr_q;
  logic              last_beat;

  assign last_beat = bus.resp_i && (cnt == cnt_w'(beats - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.write_i) begin
          state_nxt = WB;
        end else if (bus.read_i) begin
          state_nxt = FILL;
        end
      end
      FILL:    if (last_beat) state_nxt = DONE;
      WB:      if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address is stored pre-aligned so it stays stable from the first beat through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      wb_line   <= '0;
      fill_line <= '0;
      addr_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.write_i) begin
            addr_q  <= bus.address_i & line_mask;
            wb_line <= bus.line_i;
            cnt     <= '0;
          end else if (bus.read_i) begin
            addr_q <= bus.address_i & line_mask;
            cnt    <= '0;
          end
        end
        FILL: begin
          if (bus.resp_i) begin
            fill_line[int'(cnt)*s_burst +: s_burst] <= bus.burst_i;
            cnt <= cnt + 1'b1;
          end
        end
        WB: begin
          if (bus.resp_i) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.read_o    = (state == FILL);
    bus.write_o   = (state == WB);
    bus.resp_o    = (state == DONE);
    bus.address_o = addr_q;
    bus.line_o    = fill_line;
    bus.burst_o   = wb_line[int'(cnt)*s_burst +: s_burst];
  end

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Directed bench for line_burst_adaptor: fills, gapped writeback, arbitration, reset abort, held request.
module tb_line_burst_adaptor;
  import line_burst_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  line_burst_adaptor_if bus ();

  line_burst_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are then observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input string tag, input logic [31:0] addr, input logic [63:0] b [4],
                          input logic [31:0] exp_addr, input logic [255:0] exp_line);
    bus.address_i = addr;
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b0;
    bus.resp_i    = 1'b0;
    tick();
    check({tag, "_read_o"}, 256'(bus.read_o), 256'd1);
    check({tag, "_addr"}, 256'(bus.address_o), 256'(exp_addr));
    for (int k = 0; k < BEATS; k++) begin
      check({tag, "_resp_early"}, 256'(bus.resp_o), 256'd0);
      bus.resp_i  = 1'b1;
      bus.burst_i = b[k];
      tick();
    end
    bus.resp_i = 1'b0;
    check({tag, "_resp_o"}, 256'(bus.resp_o), 256'd1);
    check({tag, "_line_o"}, bus.line_o, exp_line);
    check({tag, "_read_done"}, 256'(bus.read_o), 256'd0);
    bus.read_i = 1'b0;
    tick();
    check({tag, "_resp_once"}, 256'(bus.resp_o), 256'd0);
  endtask

  logic [63:0]  wb_beats [4];
  logic [255:0] wb_line;
  logic         gap_pat  [7];
  int           k;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    tick();
    tick();
    check("rst_read_o", 256'(bus.read_o), 256'd0);
    check("rst_write_o", 256'(bus.write_o), 256'd0);
    check("rst_resp_o", 256'(bus.resp_o), 256'd0);
    check("rst_address_o", 256'(bus.address_o), 256'd0);
    check("rst_line_o", bus.line_o, 256'd0);
    check("rst_burst_o", 256'(bus.burst_o), 256'd0);
    rst = 1'b0;
    tick();

    // Contiguous fill
    run_fill("fill1", 32'h1234_5678,
             '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444},
             32'h1234_5660,
             256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Writeback with gaps; line_i is changed after latching to prove it is held internally
    wb_beats = '{64'h8796_a5b4_c3d2_e1f0, 64'h0f1e_2d3c_4b5a_6978,
                 64'hfedc_ba98_7654_3210, 64'h0123_4567_89ab_cdef};
    wb_line  = 256'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978_8796a5b4c3d2e1f0;
    gap_pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.address_i = 32'hdead_beef;
    bus.line_i    = wb_line;
    bus.write_i   = 1'b1;
    tick();
    bus.line_i = '0;
    check("wb_addr", 256'(bus.address_o), 256'(32'hdead_bee0));
    check("wb_read_o", 256'(bus.read_o), 256'd0);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      check("wb_write_o", 256'(bus.write_o), 256'd1);
      check("wb_burst_o", 256'(bus.burst_o), 256'(wb_beats[k]));
      check("wb_resp_early", 256'(bus.resp_o), 256'd0);
      bus.resp_i = gap_pat[i];
      tick();
      if (gap_pat[i]) k++;
    end
    bus.resp_i = 1'b0;
    check("wb_resp_o", 256'(bus.resp_o), 256'd1);
    check("wb_write_done", 256'(bus.write_o), 256'd0);
    bus.write_i = 1'b0;
    tick();
    check("wb_resp_once", 256'(bus.resp_o), 256'd0);

    // Simultaneous read and write: writeback wins
    bus.address_i = 32'h0000_0047;
    bus.line_i    = {4{64'h5555_aaaa_5555_aaaa}};
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    tick();
    check("both_addr", 256'(bus.address_o), 256'(32'h0000_0040));
    for (int i = 0; i < BEATS; i++) begin
      check("both_write_o", 256'(bus.write_o), 256'd1);
      check("both_read_o", 256'(bus.read_o), 256'd0);
      bus.resp_i = 1'b1;
      tick();
    end
    bus.resp_i = 1'b0;
    check("both_resp_o", 256'(bus.resp_o), 256'd1);
    check("both_read_done", 256'(bus.read_o), 256'd0);
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    tick();

    // Spurious beats while idle must not disturb the counter
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'hbad0_bad0_bad0_bad0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_read_o", 256'(bus.read_o), 256'd0);
      check("idle_resp_o", 256'(bus.resp_o), 256'd0);
    end
    bus.resp_i = 1'b0;
    run_fill("fill_spur", 32'h0000_0100,
             '{64'ha1a1_a1a1_a1a1_a1a1, 64'ha2a2_a2a2_a2a2_a2a2,
               64'ha3a3_a3a3_a3a3_a3a3, 64'ha4a4_a4a4_a4a4_a4a4},
             32'h0000_0100,
             256'ha4a4a4a4a4a4a4a4_a3a3a3a3a3a3a3a3_a2a2a2a2a2a2a2a2_a1a1a1a1a1a1a1a1);

    // Reset after two fill beats aborts the transfer
    bus.address_i = 32'h0bad_f00d;
    bus.read_i    = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'hcccc_cccc_cccc_cccc;
      tick();
    end
    bus.resp_i = 1'b0;
    rst        = 1'b1;
    tick();
    rst        = 1'b0;
    bus.read_i = 1'b0;
    check("abort_read_o", 256'(bus.read_o), 256'd0);
    check("abort_resp_o", 256'(bus.resp_o), 256'd0);
    check("abort_line_o", bus.line_o, 256'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("abort_no_resp", 256'(bus.resp_o), 256'd0);
      check("abort_idle", 256'(bus.read_o), 256'd0);
    end
    run_fill("fill_post", 32'hffff_ffff,
             '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002,
               64'h0000_0000_0000_0003, 64'h8000_0000_0000_0004},
             32'hffff_ffe0,
             256'h8000000000000004_0000000000000003_0000000000000002_0000000000000001);

    // Request held through DONE starts a second transfer
    bus.address_i = 32'h2000_001f;
    bus.read_i    = 1'b1;
    tick();
    for (int i = 0; i < BEATS; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'h7777_7777_7777_7777;
      tick();
    end
    bus.resp_i = 1'b0;
    check("held_resp_o", 256'(bus.resp_o), 256'd1);
    tick();
    check("held_idle_read_o", 256'(bus.read_o), 256'd0);
    check("held_idle_resp_o", 256'(bus.resp_o), 256'd0);
    tick();
    check("held_restart", 256'(bus.read_o), 256'd1);
    for (int i = 0; i < BEATS; i++) begin
      bus.resp_i  = 1'b1;
      bus.burst_i = 64'h9999_0000_0000_0000 | 64'(i);
      tick();
    end
    bus.resp_i = 1'b0;
    check("held2_resp_o", 256'(bus.resp_o), 256'd1);
    check("held2_line_o", bus.line_o,
          256'h9999000000000003_9999000000000002_9999000000000001_9999000000000000);
    bus.read_i = 1'b0;
    tick();
    tick();
    check("held2_idle", 256'(bus.read_o), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
